tl_inflight_tracker: RTL and testbench
======================================

TL_INFLIGHT_TRACKER -- requirements
Module: tl_inflight_tracker

Interface
REQ-001 SHALL have parameters: SOURCE_BITS, default 2, source-ID width (2^SOURCE_BITS trackers); ADDR_BITS, default 25, address width; BEAT_LOG2, default 3, log2 of bytes per beat.
REQ-002 Ports, part 1:
- clock, in, 1, sole clock; all state is updated on the rising edge.
- reset, in, 1, synchronous, active-high.
- a_valid / a_ready, in, 1 each, A-channel handshake.
- a_opcode, in, 3, A opcode.
- a_size, in, 4, log2 of transfer bytes.
- a_source, in, SOURCE_BITS, A source ID.
- a_address, in, ADDR_BITS, A address.
REQ-003 Ports, part 2:
- d_valid / d_ready, in, 1 each, D-channel handshake.
- d_opcode, in, 3, D opcode.
- d_size, in, 4, log2 of transfer bytes.
- d_source, in, SOURCE_BITS, D source ID.
REQ-004 Ports, part 3:
- inflight, out, 2^SOURCE_BITS, one bit per outstanding source.
- err_valid, out, 1, sticky error flag.
- err_code, out, 3, first error code seen.
- err_source, out, SOURCE_BITS, source that caused the first error.
- err_pulse, out, 1, one-cycle strobe on every detected error.

Function
REQ-005 A transfer fires when valid & ready; D transfer fires when d_valid & d_ready. The block is observe-only and drives no ready signal.
REQ-006 Beat count rule: an A transfer with opcode 0 or 1 (PutFull/PutPartial) and a_size > BEAT_LOG2 has 2^(a_size-BEAT_LOG2) beats; every other A transfer has 1 beat.
REQ-007 Beat count rule: a D transfer with opcode 1 (AccessAckData) and d_size > BEAT_LOG2 has 2^(d_size-BEAT_LOG2) beats; every other D transfer has 1 beat.
REQ-008 Each channel SHALL keep a beat counter (0 = idle/first beat) plus a latched copy of first-beat opcode, size, source and address. The counter wraps to 0 after the last beat.
REQ-009 On A first beat: if inflight[a_source] is already 1, and is not being cleared by a D last beat in the same cycle, raise ERR_A_DUP = 1.
REQ-010 On A first beat: if a_address is not aligned to 2^a_size, raise ERR_A_ALIGN = 2.
REQ-011 On A non-first beat: if opcode, size, source or address differs from the latched first-beat copy, raise ERR_A_CHANGE = 3.
REQ-012 inflight[a_source] SHALL be set on the A first beat.
REQ-013 On D first beat: if inflight[d_source] is 0, raise ERR_D_UNEXP = 4.
REQ-014 On D non-first beat: if opcode, size or source differs from the latched copy, raise ERR_D_CHANGE = 5.
REQ-015 inflight[d_source] SHALL be cleared on the D last beat.
REQ-016 Same-cycle D last-beat clear and A first-beat set:
- Same source: clear applies first, set second; the bit ends at 1 and no error is raised.
- Different sources: both updates apply.
REQ-017 Error priority when several errors occur in one cycle: the lower code wins for err_code; err_pulse is asserted once.
REQ-018 err_valid, err_code and err_source SHALL capture only the first error after reset and hold it until reset.
REQ-019 err_pulse SHALL be registered: 1 cycle after the offending fire, for every error.
REQ-020 inflight SHALL update the cycle after the fire.
REQ-021 Outputs SHALL be registered with no combinational input-to-output path.

Reset
REQ-022 reset SHALL clear, on the clock edge: inflight = 0, err_valid = 0, err_code = 0, err_source = 0, err_pulse = 0, both beat counters = 0, and the latched copies.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; the next fire after reset is treated as a first beat.

Structure
REQ-024 A shared package SHALL hold: the error-code enum (NONE = 0 to D_CHANGE = 5), the TL opcode constants, and a beats-from-size function.
REQ-025 The block SHALL have one sub-module, tl_beat_tracker, instantiated once per channel. It holds the counter, first/last flags and the latched fields.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Get, source 2, size 3, addr 0x100; then AccessAckData, size 3, source 2 -> inflight goes 0x4 then 0x0; err_valid = 0.
- PutFull, size 5 (4 beats), source 1; beat 3 address changes -> err_pulse on that beat +1 cycle; err_code = 3; err_source = 1.
- Two A first beats on source 0 with no D between -> err_code = 1 on the second; inflight[0] stays 1.
- AccessAck, source 3, with inflight = 0 -> err_code = 4; err_source = 3.
- Same cycle: D AccessAck last beat on source 0 and A Get first beat on source 0 -> inflight[0] = 1; no error.
- Reset after beat 2 of a 4-beat Put, then a new single-beat Get -> no ERR_A_CHANGE; inflight holds only the new source.

Source files
------------

// File: rtl/tl_inflight_tracker_pkg.sv
// Shared definitions for the TileLink in-flight tracker.
//   err_code_e   : error codes reported on err_code (lower value = higher priority)
//   opcode consts: A/D channel opcodes the tracker cares about
//   beats_m1()   : (beats - 1) for a transfer, from its data-bearing flag and size
package tl_inflight_tracker_pkg;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_A_DUP    = 3'd1,
      ERR_A_ALIGN  = 3'd2,
      ERR_A_CHANGE = 3'd3,
      ERR_D_UNEXP  = 3'd4,
      ERR_D_CHANGE = 3'd5
   } err_code_e;

   localparam logic [2:0] A_PUT_FULL        = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] A_GET             = 3'd4;
   localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

   // Largest size is 2^15 bytes, so beats-1 always fits in 16 bits.
   localparam int CNT_W = 16;

   // Returns beats-1 so a single-beat transfer yields 0.
   function automatic logic [CNT_W-1:0] beats_m1(input logic       has_data,
                                                  input logic [3:0] size,
                                                  input int         beat_log2);
      logic [CNT_W-1:0] r;
      r = '0;
      if (has_data && (int'(size) > beat_log2))
         r = (CNT_W'(1) << (int'(size) - beat_log2)) - CNT_W'(1);
      return r;
   endfunction

endpackage

// File: rtl/tl_inflight_tracker_beat.sv
// tl_beat_tracker: per-channel burst follower.
// Counts beats of the current message, latches the first-beat header and
// flags header changes on later beats.
//   clock, reset      : clock, synchronous active-high reset
//   fire_i            : a beat is transferred this cycle
//   has_data_i        : opcode carries data (multi-beat capable)
//   opcode_i..address_i : header of the current beat
//   first_o / last_o  : current beat is first / last of its message
//   change_o          : header differs from latched first-beat copy
//                       (meaningful only when first_o is 0)
module tl_beat_tracker
   import tl_inflight_tracker_pkg::*;
#(
   parameter int SOURCE_BITS = 2,
   parameter int ADDR_BITS   = 25,
   parameter int BEAT_LOG2   = 3,
   parameter bit CHECK_ADDR  = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   fire_i,
   input  logic                   has_data_i,
   input  logic [2:0]             opcode_i,
   input  logic [3:0]             size_i,
   input  logic [SOURCE_BITS-1:0] source_i,
   input  logic [ADDR_BITS-1:0]   address_i,
   output logic                   first_o,
   output logic                   last_o,
   output logic                   change_o
);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       tot_q, tot_d;
   logic [2:0]             op_q, op_d;
   logic [3:0]             size_q, size_d;
   logic [SOURCE_BITS-1:0] src_q, src_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]       beats_now;

   assign beats_now = beats_m1(has_data_i, size_i, BEAT_LOG2);
   assign first_o   = (cnt_q == '0);
   // Later beats end on the burst length latched at the first beat, so a
   // corrupted size on a later beat cannot stretch or cut the burst.
   assign last_o    = first_o ? (beats_now == '0) : (cnt_q == tot_q);
   assign change_o  = (opcode_i != op_q) || (size_i != size_q) ||
                      (source_i != src_q) ||
                      (CHECK_ADDR && (address_i != addr_q));

   always_comb begin
      cnt_d  = cnt_q;
      tot_d  = tot_q;
      op_d   = op_q;
      size_d = size_q;
      src_d  = src_q;
      addr_d = addr_q;
      if (fire_i) begin
         if (first_o) begin
            tot_d  = beats_now;
            op_d   = opcode_i;
            size_d = size_i;
            src_d  = source_i;
            addr_d = address_i;
         end
         cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         tot_q  <= '0;
         op_q   <= '0;
         size_q <= '0;
         src_q  <= '0;
         addr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         tot_q  <= tot_d;
         op_q   <= op_d;
         size_q <= size_d;
         src_q  <= src_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/tl_inflight_tracker.sv
// tl_inflight_tracker: passive TileLink A/D channel monitor.
// Tracks which source IDs have an outstanding request and flags protocol
// errors (duplicate source, misaligned address, mid-burst header change,
// unexpected response, response header change).
//   clock, reset                    : clock, synchronous active-high reset
//   a_valid/a_ready/a_opcode/a_size/a_source/a_address : A channel (observed)
//   d_valid/d_ready/d_opcode/d_size/d_source           : D channel (observed)
//   inflight   : one bit per source with an outstanding request
//   err_valid  : sticky, first error seen since reset
//   err_code   : code of first error
//   err_source : source of first error
//   err_pulse  : one-cycle strobe for every cycle with an error
// All outputs are registered and update one cycle after the fire.
module tl_inflight_tracker
   import tl_inflight_tracker_pkg::*;
#(
   parameter int SOURCE_BITS = 2,
   parameter int ADDR_BITS   = 25,
   parameter int BEAT_LOG2   = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      a_valid,
   input  logic                      a_ready,
   input  logic [2:0]                a_opcode,
   input  logic [3:0]                a_size,
   input  logic [SOURCE_BITS-1:0]    a_source,
   input  logic [ADDR_BITS-1:0]      a_address,
   input  logic                      d_valid,
   input  logic                      d_ready,
   input  logic [2:0]                d_opcode,
   input  logic [3:0]                d_size,
   input  logic [SOURCE_BITS-1:0]    d_source,
   output logic [(1<<SOURCE_BITS)-1:0] inflight,
   output logic                      err_valid,
   output logic [2:0]                err_code,
   output logic [SOURCE_BITS-1:0]    err_source,
   output logic                      err_pulse
);

   localparam int NSRC = 1 << SOURCE_BITS;

   logic a_fire, d_fire;
   logic a_has_data, d_has_data;
   logic a_first, a_last, a_change;
   logic d_first, d_last, d_change;
   logic d_clear, a_set;
   logic misalign;

   logic [NSRC-1:0]        inflight_q, inflight_d;
   logic                   err_valid_q, err_valid_d;
   logic [2:0]             err_code_q, err_code_d;
   logic [SOURCE_BITS-1:0] err_source_q, err_source_d;
   logic                   err_pulse_q, err_pulse_d;

   err_code_e              hit_code;
   logic [SOURCE_BITS-1:0] hit_src;

   assign a_fire     = a_valid & a_ready;
   assign d_fire     = d_valid & d_ready;
   assign a_has_data = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
   assign d_has_data = (d_opcode == D_ACCESS_ACK_DATA);

   tl_beat_tracker #(
      .SOURCE_BITS (SOURCE_BITS),
      .ADDR_BITS   (ADDR_BITS),
      .BEAT_LOG2   (BEAT_LOG2),
      .CHECK_ADDR  (1'b1)
   ) u_a_beats (
      .clock      (clock),
      .reset      (reset),
      .fire_i     (a_fire),
      .has_data_i (a_has_data),
      .opcode_i   (a_opcode),
      .size_i     (a_size),
      .source_i   (a_source),
      .address_i  (a_address),
      .first_o    (a_first),
      .last_o     (a_last),
      .change_o   (a_change)
   );

   // D carries no address; the tracker sees a constant and skips the compare.
   tl_beat_tracker #(
      .SOURCE_BITS (SOURCE_BITS),
      .ADDR_BITS   (1),
      .BEAT_LOG2   (BEAT_LOG2),
      .CHECK_ADDR  (1'b0)
   ) u_d_beats (
      .clock      (clock),
      .reset      (reset),
      .fire_i     (d_fire),
      .has_data_i (d_has_data),
      .opcode_i   (d_opcode),
      .size_i     (d_size),
      .source_i   (d_source),
      .address_i  (1'b0),
      .first_o    (d_first),
      .last_o     (d_last),
      .change_o   (d_change)
   );

   assign d_clear = d_fire & d_last;
   assign a_set   = a_fire & a_first;

   // Any address bit below log2(size) set means misaligned; sizes wider
   // than the address simply check every bit.
   always_comb begin
      misalign = 1'b0;
      for (int i = 0; i < ADDR_BITS; i++)
         if (a_address[i] && (i < int'(a_size))) misalign = 1'b1;
   end

   // Priority chain: lowest error code wins.
   always_comb begin
      hit_code = ERR_NONE;
      hit_src  = '0;
      if (a_set && inflight_q[a_source] && !(d_clear && (d_source == a_source))) begin
         hit_code = ERR_A_DUP;
         hit_src  = a_source;
      end else if (a_set && misalign) begin
         hit_code = ERR_A_ALIGN;
         hit_src  = a_source;
      end else if (a_fire && !a_first && a_change) begin
         hit_code = ERR_A_CHANGE;
         hit_src  = a_source;
      end else if (d_fire && d_first && !inflight_q[d_source]) begin
         hit_code = ERR_D_UNEXP;
         hit_src  = d_source;
      end else if (d_fire && !d_first && d_change) begin
         hit_code = ERR_D_CHANGE;
         hit_src  = d_source;
      end
   end

   always_comb begin
      // Clear before set so a same-source retire/reissue leaves the bit at 1.
      inflight_d = inflight_q;
      if (d_clear) inflight_d[d_source] = 1'b0;
      if (a_set)   inflight_d[a_source] = 1'b1;

      err_pulse_d  = (hit_code != ERR_NONE);
      err_valid_d  = err_valid_q;
      err_code_d   = err_code_q;
      err_source_d = err_source_q;
      if (err_pulse_d && !err_valid_q) begin
         err_valid_d  = 1'b1;
         err_code_d   = hit_code;
         err_source_d = hit_src;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight_q   <= '0;
         err_valid_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
         err_source_q <= '0;
         err_pulse_q  <= 1'b0;
      end else begin
         inflight_q   <= inflight_d;
         err_valid_q  <= err_valid_d;
         err_code_q   <= err_code_d;
         err_source_q <= err_source_d;
         err_pulse_q  <= err_pulse_d;
      end
   end

   assign inflight   = inflight_q;
   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;
   assign err_source = err_source_q;
   assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Directed scoreboard bench for tl_inflight_tracker (default parameters).
// Each driven cycle pushes its expected post-edge outputs; they are popped
// and compared #1 after the clock edge that consumes the stimulus.
module tb_tl_inflight_tracker;

   logic        clock = 1'b0;
   logic        reset;
   logic        a_valid, a_ready, d_valid, d_ready;
   logic [2:0]  a_opcode, d_opcode;
   logic [3:0]  a_size, d_size;
   logic [1:0]  a_source, d_source;
   logic [24:0] a_address;
   logic [3:0]  inflight;
   logic        err_valid, err_pulse;
   logic [2:0]  err_code;
   logic [1:0]  err_source;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string      tag;
      logic [3:0] inf;
      logic       pulse;
      logic       valid;
      logic [2:0] code;
      logic [1:0] src;
   } exp_t;

   exp_t sb[$];

   tl_inflight_tracker dut (
      .clock      (clock),
      .reset      (reset),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_opcode   (a_opcode),
      .a_size     (a_size),
      .a_source   (a_source),
      .a_address  (a_address),
      .d_valid    (d_valid),
      .d_ready    (d_ready),
      .d_opcode   (d_opcode),
      .d_size     (d_size),
      .d_source   (d_source),
      .inflight   (inflight),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_source (err_source),
      .err_pulse  (err_pulse)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_and_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".inflight"},   32'(inflight),   32'(e.inf));
      chk({e.tag, ".err_pulse"},  32'(err_pulse),  32'(e.pulse));
      chk({e.tag, ".err_valid"},  32'(err_valid),  32'(e.valid));
      chk({e.tag, ".err_code"},   32'(err_code),   32'(e.code));
      chk({e.tag, ".err_source"}, 32'(err_source), 32'(e.src));
   endtask

   task automatic push(input string tag, input logic [3:0] inf, input logic pulse,
                       input logic valid, input logic [2:0] code, input logic [1:0] src);
      exp_t e;
      e.tag = tag; e.inf = inf; e.pulse = pulse; e.valid = valid; e.code = code; e.src = src;
      sb.push_back(e);
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b1;
      a_valid = 1'b0;
      d_valid = 1'b0;
      push(tag, 4'h0, 1'b0, 1'b0, 3'd0, 2'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      pop_and_check();
   endtask

   // One cycle: drive A/D (valid=0 means idle), expect outputs after the edge.
   task automatic step(input string tag,
                       input logic av, input logic [2:0] aop, input logic [3:0] asz,
                       input logic [1:0] asrc, input logic [24:0] aadr,
                       input logic dv, input logic [2:0] dop, input logic [3:0] dsz,
                       input logic [1:0] dsrc,
                       input logic [3:0] e_inf, input logic e_pulse, input logic e_valid,
                       input logic [2:0] e_code, input logic [1:0] e_src);
      a_valid = av; a_opcode = aop; a_size = asz; a_source = asrc; a_address = aadr;
      d_valid = dv; d_opcode = dop; d_size = dsz; d_source = dsrc;
      push(tag, e_inf, e_pulse, e_valid, e_code, e_src);
      @(posedge clock); #1;
      a_valid = 1'b0;
      d_valid = 1'b0;
      pop_and_check();
   endtask

   localparam logic [2:0] PUT = 3'd0, GET = 3'd4, ACK = 3'd0, ACKD = 3'd1;

   initial begin
      reset = 1'b1;
      a_valid = 0; a_ready = 1; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0;
      d_valid = 0; d_ready = 1; d_opcode = 0; d_size = 0; d_source = 0;
      @(posedge clock); #1;
      do_reset("rst0");

      // Get/AccessAckData round trip; a_ready low must not fire.
      a_ready = 1'b0;
      step("nofire", 1, GET, 4'd3, 2'd2, 25'h100, 0, ACK, 4'd0, 2'd0, 4'h0, 0, 0, 3'd0, 2'd0);
      a_ready = 1'b1;
      step("get2",   1, GET, 4'd3, 2'd2, 25'h100, 0, ACK, 4'd0, 2'd0, 4'h4, 0, 0, 3'd0, 2'd0);
      step("ackd2",  0, GET, 4'd0, 2'd0, 25'h0,   1, ACKD, 4'd3, 2'd2, 4'h0, 0, 0, 3'd0, 2'd0);
      // 4-beat AccessAckData retires only on its last beat.
      step("get1",   1, GET, 4'd5, 2'd1, 25'h20,  0, ACK, 4'd0, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);
      for (int b = 1; b <= 4; b++)
         step($sformatf("ackd4_b%0d", b), 0, GET, 4'd0, 2'd0, 25'h0, 1, ACKD, 4'd5, 2'd1,
              (b == 4) ? 4'h0 : 4'h2, 0, 0, 3'd0, 2'd0);

      // PutFull 4 beats, beat 3 changes address.
      do_reset("rst1");
      step("put_b1", 1, PUT, 4'd5, 2'd1, 25'h20, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);
      step("put_b2", 1, PUT, 4'd5, 2'd1, 25'h20, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);
      step("put_b3", 1, PUT, 4'd5, 2'd1, 25'h28, 0, ACK, 4'd0, 2'd0, 4'h2, 1, 1, 3'd3, 2'd1);
      step("put_b4", 1, PUT, 4'd5, 2'd1, 25'h20, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 1, 3'd3, 2'd1);
      step("put_idle", 0, PUT, 4'd0, 2'd0, 25'h0, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 1, 3'd3, 2'd1);

      // Duplicate source 0.
      do_reset("rst2");
      step("dup_a",  1, GET, 4'd2, 2'd0, 25'h0, 0, ACK, 4'd0, 2'd0, 4'h1, 0, 0, 3'd0, 2'd0);
      step("dup_b",  1, GET, 4'd2, 2'd0, 25'h0, 0, ACK, 4'd0, 2'd0, 4'h1, 1, 1, 3'd1, 2'd0);
      step("dup_idle", 0, GET, 4'd0, 2'd0, 25'h0, 0, ACK, 4'd0, 2'd0, 4'h1, 0, 1, 3'd1, 2'd0);

      // Unexpected AccessAck on source 3.
      do_reset("rst3");
      step("unexp",  0, GET, 4'd0, 2'd0, 25'h0, 1, ACK, 4'd3, 2'd3, 4'h0, 1, 1, 3'd4, 2'd3);

      // Same-cycle retire and reissue on source 0, then on different sources.
      do_reset("rst4");
      step("sc_get", 1, GET, 4'd3, 2'd0, 25'h0, 0, ACK, 4'd0, 2'd0, 4'h1, 0, 0, 3'd0, 2'd0);
      step("sc_same", 1, GET, 4'd3, 2'd0, 25'h0, 1, ACK, 4'd3, 2'd0, 4'h1, 0, 0, 3'd0, 2'd0);
      step("sc_diff", 1, GET, 4'd3, 2'd1, 25'h8, 1, ACK, 4'd3, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);

      // Reset mid-burst abandons it.
      do_reset("rst5");
      step("mb_b1",  1, PUT, 4'd5, 2'd1, 25'h40, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);
      step("mb_b2",  1, PUT, 4'd5, 2'd1, 25'h40, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);
      do_reset("rst_mid");
      step("mb_get", 1, GET, 4'd3, 2'd2, 25'h108, 0, ACK, 4'd0, 2'd0, 4'h4, 0, 0, 3'd0, 2'd0);

      // Misalignment, and A_ALIGN beats a same-cycle D_UNEXP.
      do_reset("rst6");
      step("align",  1, GET, 4'd3, 2'd0, 25'h104, 1, ACK, 4'd3, 2'd3, 4'h1, 1, 1, 3'd2, 2'd0);

      // Duplicate + misaligned in one cycle: A_DUP wins, single pulse.
      do_reset("rst7");
      step("pr_a",   1, GET, 4'd3, 2'd3, 25'h100, 0, ACK, 4'd0, 2'd0, 4'h8, 0, 0, 3'd0, 2'd0);
      step("pr_b",   1, GET, 4'd3, 2'd3, 25'h104, 0, ACK, 4'd0, 2'd0, 4'h8, 1, 1, 3'd1, 2'd3);

      // D size changes on beat 2 of a 2-beat AccessAckData.
      do_reset("rst8");
      step("dc_get", 1, GET, 4'd4, 2'd1, 25'h10, 0, ACK, 4'd0, 2'd0, 4'h2, 0, 0, 3'd0, 2'd0);
      step("dc_b1",  0, GET, 4'd0, 2'd0, 25'h0, 1, ACKD, 4'd4, 2'd1, 4'h2, 0, 0, 3'd0, 2'd0);
      step("dc_b2",  0, GET, 4'd0, 2'd0, 25'h0, 1, ACKD, 4'd3, 2'd1, 4'h0, 1, 1, 3'd5, 2'd1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
